// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester ports plus memory channel shared by the arbiter
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic          data_wr;
  logic [3:0]    data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          mem_req;
  logic          mem_wr;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok;
  logic          mem_data_ok;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
           mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
  );
  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
           mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises inst/data ports onto one memory channel; ARB_ROUND_ROBIN_EN selects round-robin on conflicts
module mem_port_arbiter #(parameter int AW = 32, parameter int DW = 32) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic owner, last_grant, pick, wr_q;
  logic [3:0] wstrb_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
  assign pick = bus.data_req & (~bus.inst_req | ~last_grant);
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign pick = bus.data_req;
`endif
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (bus.inst_req | bus.data_req ? REQ : IDLE) :
               state == REQ  ? (bus.mem_addr_ok ? RESP : REQ) :
               state == RESP ? (bus.mem_data_ok ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      wr_q       <= 1'b0;
      wstrb_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (bus.inst_req | bus.data_req)) begin
        owner   <= pick;
        wr_q    <= pick & bus.data_wr;
        wstrb_q <= pick ? bus.data_wstrb : '0;
        addr_q  <= pick ? bus.data_addr : bus.inst_addr;
        wdata_q <= pick ? bus.data_wdata : '0;
      end
      if (state == REQ && bus.mem_addr_ok) last_grant <= owner;
    end
  end
  assign bus.mem_req      = state == REQ;
  assign bus.mem_wr       = wr_q;
  assign bus.mem_wstrb    = wstrb_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.inst_addr_ok = state == REQ & bus.mem_addr_ok & ~owner;
  assign bus.data_addr_ok = state == REQ & bus.mem_addr_ok & owner;
  assign bus.inst_data_ok = state == RESP & bus.mem_data_ok & ~owner;
  assign bus.data_data_ok = state == RESP & bus.mem_data_ok & owner;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with requester and memory models for mem_port_arbiter
module tb_mem_port_arbiter;
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } item_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.AW(32), .DW(32)) b ();
  mem_port_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .bus(b));
  item_t todo_i[$], todo_d[$], sc_i[$], sc_d[$];
  bit exp_grant[$];
  int total = 0, bad = 0, bp = 0, dbp = 0, wcnt = 0, m_state = 0, mreq_n = 0;
  bit m_owner = 0, stray = 0, i_acc = 0, d_acc = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic item_t front(input bit g);
    if (g && sc_d.size() > 0) return sc_d[0];
    if (!g && sc_i.size() > 0) return sc_i[0];
    return '0;
  endfunction
  task automatic put(input bit port, input logic [31:0] addr, input logic wr,
                     input logic [3:0] ws, input logic [31:0] wd, input logic [31:0] rd);
    item_t it;
    it.addr = addr; it.wr = wr; it.wstrb = ws; it.wdata = wd; it.rdata = rd;
    if (port) todo_d.push_back(it);
    else todo_i.push_back(it);
  endtask
  // one clock: drive at negedge, check 1ns later, then advance the reference FSM
  task automatic step();
    item_t it, f;
    bit ia, rd;
    @(negedge clk);
    rst = 0;
    if (i_acc) b.inst_req = 0;
    if (d_acc) b.data_req = 0;
    i_acc = 0;
    d_acc = 0;
    if (!b.inst_req && todo_i.size() > 0) begin
      it = todo_i.pop_front();
      b.inst_req = 1; b.inst_addr = it.addr;
      sc_i.push_back(it);
    end
    if (!b.data_req && todo_d.size() > 0) begin
      it = todo_d.pop_front();
      b.data_req = 1; b.data_wr = it.wr; b.data_wstrb = it.wstrb;
      b.data_addr = it.addr; b.data_wdata = it.wdata;
      sc_d.push_back(it);
    end
    f = front(m_owner);
    rd = m_state == 2 && (wcnt >= dbp || stray);
    b.mem_addr_ok = m_state == 1 && wcnt >= bp;
    b.mem_data_ok = rd | stray;
    b.mem_rdata = rd ? f.rdata : $urandom;
    #1;
    ia = b.mem_addr_ok && m_state == 1;
    chk("mem_req", b.mem_req, m_state == 1);
    if (m_state == 1) begin
      mreq_n++;
      chk("mem_addr", b.mem_addr, f.addr);
      chk("mem_wr", b.mem_wr, f.wr);
      chk("mem_wstrb", b.mem_wstrb, f.wstrb);
      if (m_owner) chk("mem_wdata", b.mem_wdata, f.wdata);
    end
    chk("inst_addr_ok", b.inst_addr_ok, ia & !m_owner);
    chk("data_addr_ok", b.data_addr_ok, ia & m_owner);
    chk("inst_data_ok", b.inst_data_ok, rd & !m_owner);
    chk("data_data_ok", b.data_data_ok, rd & m_owner);
    if (rd && m_owner) begin
      chk("data_rdata", b.data_rdata, f.rdata);
      void'(sc_d.pop_front());
    end else if (rd) begin
      chk("inst_rdata", b.inst_rdata, f.rdata);
      void'(sc_i.pop_front());
    end
    i_acc = ia & !m_owner;
    d_acc = ia & m_owner;
    wcnt++;
    if (m_state == 0 && (b.inst_req || b.data_req)) begin
      if (exp_grant.size() > 0) m_owner = exp_grant.pop_front();
      else begin
        chk("grant_q", exp_grant.size(), 1);
        m_owner = b.data_req;
      end
      m_state = 1;
      wcnt = 0;
    end else if (ia) begin
      m_state = 2;
      wcnt = 0;
    end else if (rd) m_state = 0;
  endtask
  task automatic run(input int max);
    int n = 0;
    while ((todo_i.size() > 0 || todo_d.size() > 0 || sc_i.size() > 0 || sc_d.size() > 0 ||
            m_state != 0) && n < max) begin
      step();
      n++;
    end
    chk("timeout", n >= max, 0);
    chk("grant_left", exp_grant.size(), 0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1;
    m_state = 0; i_acc = 0; d_acc = 0;
    b.inst_req = 0; b.data_req = 0;
  endtask
  initial begin
    b.inst_req = 0; b.inst_addr = 0; b.data_req = 0; b.data_wr = 0; b.data_wstrb = 0;
    b.data_addr = 0; b.data_wdata = 0; b.mem_addr_ok = 1; b.mem_data_ok = 1; b.mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", b.mem_req, 0);
    chk("rst_mem_wr", b.mem_wr, 0);
    chk("rst_mem_wstrb", b.mem_wstrb, 0);
    chk("rst_mem_addr", b.mem_addr, 0);
    chk("rst_mem_wdata", b.mem_wdata, 0);
    chk("rst_oks", {b.inst_addr_ok, b.inst_data_ok, b.data_addr_ok, b.data_data_ok}, 0);
    mreq_n = 0;
    put(0, 32'hBFC00000, 0, 4'b0000, 32'h0, 32'h3C080001);
    exp_grant.push_back(0);
    run(20);
    chk("fetch_req_cycles", mreq_n, 1);
    bp = 3;
    mreq_n = 0;
    put(1, 32'h00000102, 1, 4'b0100, 32'h00AB0000, 32'h0);
    exp_grant.push_back(1);
    run(30);
    chk("store_req_cycles", mreq_n, 4);
    stray = 1;
    repeat (3) step();
    bp = 2;
    put(0, 32'h00001000, 0, 4'b0000, 32'h0, $urandom);
    exp_grant.push_back(0);
    run(20);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      bp = $urandom_range(0, 2);
      dbp = $urandom_range(0, 2);
      put(i[0], $urandom, i[0] & i[1], i[0] ? 4'($urandom) : 4'b0000,
          i[0] ? $urandom : 32'h0, $urandom);
      exp_grant.push_back(i[0]);
      run(30);
    end
    bp = 0;
    dbp = 0;
    pulse_reset();
    for (int i = 0; i < 2; i++) put(0, 32'h00400000 + 32'(i * 4), 0, 4'b0000, 32'h0, $urandom);
    for (int i = 0; i < 4; i++) put(1, 32'h10000000 + 32'(i * 4), i[0], 4'b1111, $urandom, $urandom);
`ifdef ARB_ROUND_ROBIN_EN
    exp_grant = '{1, 0, 1, 0, 1, 1};
`else
    exp_grant = '{1, 1, 1, 1, 0, 0};
`endif
    run(100);
    dbp = 4;
    put(0, 32'h00008000, 0, 4'b0000, 32'h0, $urandom);
    put(0, 32'h00008004, 0, 4'b0000, 32'h0, 32'h24020007);
    exp_grant.push_back(0);
    for (int n = 0; n < 10 && m_state != 2; n++) step();
    step();
    chk("pre_rst_state", m_state, 2);
    @(negedge clk);
    rst = 1;
    b.mem_data_ok = 1;
    #1;
    chk("midrst_mem_req", b.mem_req, 0);
    chk("midrst_oks", {b.inst_addr_ok, b.inst_data_ok, b.data_addr_ok, b.data_data_ok}, 0);
    m_state = 0; i_acc = 0; d_acc = 0;
    void'(sc_i.pop_front());
    exp_grant.push_back(0);
    stray = 1;
    dbp = 0;
    step();
    stray = 0;
    mreq_n = 0;
    run(20);
    chk("post_rst_req_cycles", mreq_n, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
